attn_job_sequencer: RTL and testbench

- Front/back-end sequencer for the 8x8 attention core.
- Upstream side: accepts a 16-bit word stream (valid/ready) and assembles the three 512-bit operand buses (key, query, value).
- Core side: holds the core enable for one job, waits for its done level, captures the 512-bit result.
- Downstream side: streams the result out as 32 words (valid/ready, last flag). The core is cleared between jobs by dropping its enable.

---
 rtl/attn_job_sequencer_if.sv | 31 +++
 rtl/attn_job_sequencer.sv | 111 +++++++++++
 tb/tb_attn_job_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/attn_job_sequencer_if.sv
// rtl/attn_job_sequencer_if.sv - operand/result handshake bundle between sequencer, source, sink and core
interface attn_job_sequencer_if;
  logic [15:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [511:0] key;
  logic [511:0] query;
  logic [511:0] value;
  logic         attn_en;
  logic         attn_done;
  logic [511:0] attn_res;
  logic [15:0]  m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic         busy;
  logic         timeout_err;
  logic [15:0]  jobs_done;

  modport slave (
    input  s_data, s_valid, attn_done, attn_res, m_ready,
    output s_ready, key, query, value, attn_en, m_data, m_valid, m_last,
           busy, timeout_err, jobs_done
  );

  modport master (
    output s_data, s_valid, attn_done, attn_res, m_ready,
    input  s_ready, key, query, value, attn_en, m_data, m_valid, m_last,
           busy, timeout_err, jobs_done
  );
endinterface

// File: rtl/attn_job_sequencer.sv
// rtl/attn_job_sequencer.sv - loads 96 operand words, runs the attention core, drains 32 result words
module attn_job_sequencer #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  attn_job_sequencer_if.slave bus
);

  localparam int RUN_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

  state_t             r_state;
  logic [6:0]         r_in_cnt;
  logic [RUN_W-1:0]   r_run_cnt;
  logic [4:0]         r_out_cnt;
  logic [511:0]       r_key;
  logic [511:0]       r_query;
  logic [511:0]       r_value;
  logic [511:0]       r_res_buf;
  logic               r_attn_en;
  logic               r_timeout_err;
  logic [15:0]        r_jobs_done;

  logic               w_s_hs;
  logic               w_m_hs;
  logic [8:0]         w_in_idx;

  assign w_s_hs   = (r_state == LOAD)  && bus.s_valid;
  assign w_m_hs   = (r_state == DRAIN) && bus.m_ready;
  // Word position inside whichever 512-bit bus the upper count bits select.
  assign w_in_idx = {r_in_cnt[4:0], 4'b0000};

  assign bus.s_ready     = (r_state == LOAD);
  assign bus.m_valid     = (r_state == DRAIN);
  assign bus.busy        = (r_state != LOAD);
  assign bus.m_data      = r_res_buf[{r_out_cnt, 4'b0000} +: DATA_W];
  assign bus.m_last      = (r_state == DRAIN) && (r_out_cnt == 5'd31);
  assign bus.key         = r_key;
  assign bus.query       = r_query;
  assign bus.value       = r_value;
  assign bus.attn_en     = r_attn_en;
  assign bus.timeout_err = r_timeout_err;
  assign bus.jobs_done   = r_jobs_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= LOAD;
      r_in_cnt      <= '0;
      r_run_cnt     <= '0;
      r_out_cnt     <= '0;
      r_key         <= '0;
      r_query       <= '0;
      r_value       <= '0;
      r_res_buf     <= '0;
      r_attn_en     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_jobs_done   <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_s_hs) begin
            if (r_in_cnt == 7'd0) r_timeout_err <= 1'b0;
            case (r_in_cnt[6:5])
              2'd0:    r_key[w_in_idx +: DATA_W]   <= bus.s_data;
              2'd1:    r_query[w_in_idx +: DATA_W] <= bus.s_data;
              default: r_value[w_in_idx +: DATA_W] <= bus.s_data;
            endcase
            if (r_in_cnt == 7'd95) begin
              r_in_cnt  <= '0;
              r_run_cnt <= '0;
              r_attn_en <= 1'b1;
              r_state   <= RUN;
            end else begin
              r_in_cnt <= r_in_cnt + 7'd1;
            end
          end
        end
        RUN: begin
          r_run_cnt <= r_run_cnt + 1'b1;
          // Done takes priority over a coincident timeout.
          if (bus.attn_done) begin
            r_res_buf   <= bus.attn_res;
            r_attn_en   <= 1'b0;
            r_out_cnt   <= '0;
            r_jobs_done <= r_jobs_done + 16'd1;
            r_state     <= DRAIN;
          end else if (r_run_cnt == RUN_W'(TIMEOUT_CYCLES - 1)) begin
            r_attn_en     <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= LOAD;
          end
        end
        DRAIN: begin
          if (w_m_hs) begin
            if (r_out_cnt == 5'd31) begin
              r_out_cnt <= '0;
              r_state   <= LOAD;
            end else begin
              r_out_cnt <= r_out_cnt + 5'd1;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_attn_job_sequencer.sv
// tb/tb_attn_job_sequencer.sv - directed bench for attn_job_sequencer with a second short-timeout instance
module tb_attn_job_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic to_mvalid_seen = 1'b0;

  attn_job_sequencer_if m_if ();
  attn_job_sequencer_if t_if ();

  attn_job_sequencer #(.DATA_W(16), .TIMEOUT_CYCLES(4096)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(m_if.slave)
  );

  attn_job_sequencer #(.DATA_W(16), .TIMEOUT_CYCLES(8)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .bus(t_if.slave)
  );

  // The short-timeout instance shares the input stream but its core never finishes.
  assign t_if.s_data    = m_if.s_data;
  assign t_if.s_valid   = m_if.s_valid;
  assign t_if.m_ready   = m_if.m_ready;
  assign t_if.attn_done = 1'b0;
  assign t_if.attn_res  = '0;

  always #5 clk = ~clk;

  always @(posedge clk) if (t_if.m_valid) to_mvalid_seen <= 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_res(input logic [15:0] base);
    for (int k = 0; k < 32; k++) m_if.attn_res[k*16 +: 16] = base + 16'(k);
  endtask

  task automatic load_full(input logic [15:0] base);
    for (int i = 0; i < 96; i++) begin
      m_if.s_valid = 1'b1;
      m_if.s_data  = base + 16'(i);
      tick();
    end
    m_if.s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int p;
    logic [3:0] pat;
    pat = 4'b1001;
    rst_n = 1'b0;
    m_if.s_valid = 1'b0;
    m_if.s_data = '0;
    m_if.m_ready = 1'b0;
    m_if.attn_done = 1'b0;
    m_if.attn_res = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(m_if.s_ready), 1);
    chk("rst_attn_en", 32'(m_if.attn_en), 0);
    chk("rst_busy", 32'(m_if.busy), 0);
    chk("rst_m_valid", 32'(m_if.m_valid), 0);
    chk("rst_m_last", 32'(m_if.m_last), 0);
    chk("rst_jobs", 32'(m_if.jobs_done), 0);
    chk("rst_terr", 32'(m_if.timeout_err), 0);
    chk("rst_key", m_if.key[31:0], 0);
    rst_n = 1'b1;
    tick();

    // Job 1: contiguous load
    for (int i = 0; i < 96; i++) begin
      m_if.s_valid = 1'b1;
      m_if.s_data  = 16'(i + 1);
      if (i == 0)  chk("j1_s_ready_first", 32'(m_if.s_ready), 1);
      if (i == 95) begin
        chk("j1_s_ready_last", 32'(m_if.s_ready), 1);
        chk("j1_en_before", 32'(m_if.attn_en), 0);
      end
      tick();
    end
    m_if.s_valid = 1'b0;
    chk("j1_en_after", 32'(m_if.attn_en), 1);
    chk("j1_s_ready_run", 32'(m_if.s_ready), 0);
    chk("j1_busy", 32'(m_if.busy), 1);
    chk("j1_key0", 32'(m_if.key[15:0]), 32'h0001);
    chk("j1_key31", 32'(m_if.key[511:496]), 32'h0020);
    chk("j1_query0", 32'(m_if.query[15:0]), 32'h0021);
    chk("j1_value31", 32'(m_if.value[511:496]), 32'h0060);
    chk("to_en_start", 32'(t_if.attn_en), 1);

    for (int c = 1; c < 50; c++) begin
      tick();
      if (c == 7) begin
        chk("to_en_c7", 32'(t_if.attn_en), 1);
        chk("to_terr_c7", 32'(t_if.timeout_err), 0);
      end
      if (c == 8) begin
        chk("to_en_c8", 32'(t_if.attn_en), 0);
        chk("to_terr_c8", 32'(t_if.timeout_err), 1);
        chk("to_s_ready_c8", 32'(t_if.s_ready), 1);
        chk("to_busy_c8", 32'(t_if.busy), 0);
      end
    end
    chk("j1_en_c49", 32'(m_if.attn_en), 1);
    chk("j1_m_valid_c49", 32'(m_if.m_valid), 0);
    m_if.attn_done = 1'b1;
    set_res(16'h1000);
    m_if.m_ready = 1'b1;
    tick();
    m_if.attn_done = 1'b0;
    chk("j1_en_done", 32'(m_if.attn_en), 0);
    chk("j1_jobs", 32'(m_if.jobs_done), 1);
    for (int k = 0; k < 32; k++) begin
      chk("j1_m_valid", 32'(m_if.m_valid), 1);
      chk("j1_m_data", 32'(m_if.m_data), 32'h1000 + k);
      chk("j1_m_last", 32'(m_if.m_last), (k == 31) ? 1 : 0);
      if (k == 5) begin
        m_if.attn_done = 1'b1;
        set_res(16'hDEAD);
      end
      tick();
    end
    chk("j1_m_valid_end", 32'(m_if.m_valid), 0);
    chk("j1_s_ready_end", 32'(m_if.s_ready), 1);
    chk("j1_busy_end", 32'(m_if.busy), 0);
    chk("j1_jobs_end", 32'(m_if.jobs_done), 1);

    // Job 2: gapped load with attn_done held high in LOAD
    chk("to_terr_before_j2", 32'(t_if.timeout_err), 1);
    idx = 0;
    p = 0;
    while (idx < 96 && p < 400) begin
      m_if.s_valid = (p % 3) != 2;
      m_if.s_data  = 16'h0100 + 16'(idx);
      tick();
      if (m_if.s_valid) begin
        idx++;
        if (idx == 1) chk("to_terr_cleared", 32'(t_if.timeout_err), 0);
        if (idx == 50) begin
          chk("j2_busy_load", 32'(m_if.busy), 0);
          chk("j2_jobs_load", 32'(m_if.jobs_done), 1);
        end
      end
      p++;
    end
    m_if.s_valid = 1'b0;
    m_if.attn_done = 1'b0;
    chk("j2_load_count", 32'(idx), 96);
    chk("j2_en", 32'(m_if.attn_en), 1);
    chk("j2_key0", 32'(m_if.key[15:0]), 32'h0100);
    chk("j2_value31", 32'(m_if.value[511:496]), 32'h015F);
    repeat (4) tick();
    m_if.attn_done = 1'b1;
    set_res(16'h2000);
    tick();
    m_if.attn_done = 1'b0;
    chk("j2_jobs", 32'(m_if.jobs_done), 2);
    idx = 0;
    p = 0;
    while (idx < 32 && p < 200) begin
      m_if.m_ready = pat[3 - (p % 4)];
      chk("j2_m_valid", 32'(m_if.m_valid), 1);
      chk("j2_m_data", 32'(m_if.m_data), 32'h2000 + idx);
      chk("j2_m_last", 32'(m_if.m_last), (idx == 31) ? 1 : 0);
      tick();
      if (m_if.m_ready) idx++;
      p++;
    end
    chk("j2_drain_count", 32'(idx), 32);
    chk("j2_m_valid_end", 32'(m_if.m_valid), 0);
    m_if.m_ready = 1'b0;

    // Reset in the middle of a load
    for (int i = 0; i < 40; i++) begin
      m_if.s_valid = 1'b1;
      m_if.s_data  = 16'h0300 + 16'(i);
      tick();
    end
    m_if.s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rl_s_ready", 32'(m_if.s_ready), 1);
    chk("rl_attn_en", 32'(m_if.attn_en), 0);
    chk("rl_busy", 32'(m_if.busy), 0);
    chk("rl_key0", 32'(m_if.key[15:0]), 0);
    chk("rl_query0", 32'(m_if.query[15:0]), 0);
    chk("rl_jobs", 32'(m_if.jobs_done), 0);
    chk("rl_to_terr", 32'(t_if.timeout_err), 0);
    tick();
    rst_n = 1'b1;
    tick();
    load_full(16'h0400);
    chk("rl_en", 32'(m_if.attn_en), 1);
    chk("rl_key0_fresh", 32'(m_if.key[15:0]), 32'h0400);
    chk("rl_value31_fresh", 32'(m_if.value[511:496]), 32'h045F);
    repeat (2) tick();
    m_if.attn_done = 1'b1;
    set_res(16'h3000);
    tick();
    m_if.attn_done = 1'b0;
    tick();
    chk("rd_m_valid", 32'(m_if.m_valid), 1);
    chk("rd_m_data", 32'(m_if.m_data), 32'h3000);

    // Reset during a stalled drain
    rst_n = 1'b0;
    #1;
    chk("rd_m_valid_rst", 32'(m_if.m_valid), 0);
    chk("rd_busy_rst", 32'(m_if.busy), 0);
    chk("rd_jobs_rst", 32'(m_if.jobs_done), 0);
    chk("rd_m_data_rst", 32'(m_if.m_data), 0);
    chk("rd_value_rst", 32'(m_if.value[511:496]), 0);
    chk("rd_en_rst", 32'(m_if.attn_en), 0);
    tick();
    rst_n = 1'b1;
    tick();
    load_full(16'h0500);
    chk("fr_en", 32'(m_if.attn_en), 1);
    chk("fr_query0", 32'(m_if.query[15:0]), 32'h0520);
    repeat (3) tick();
    m_if.attn_done = 1'b1;
    set_res(16'h4000);
    m_if.m_ready = 1'b1;
    tick();
    m_if.attn_done = 1'b0;
    for (int k = 0; k < 32; k++) begin
      chk("fr_m_data", 32'(m_if.m_data), 32'h4000 + k);
      chk("fr_m_last", 32'(m_if.m_last), (k == 31) ? 1 : 0);
      tick();
    end
    chk("fr_m_valid_end", 32'(m_if.m_valid), 0);
    chk("fr_jobs", 32'(m_if.jobs_done), 1);
    chk("to_m_valid_never", 32'(to_mvalid_seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
